// File: rtl/up_down_bcd_counter_if.sv
// Bus bundle for one up_down_bcd_counter stage: load/count controls in, count and cascade strobes out.
// The controlling side (stimulus or the previous stage) uses master; the counter uses slave.
interface up_down_bcd_counter_if;
    logic       LOAD;
    logic [3:0] D;
    logic       UP;
    logic       DN;
    logic [3:0] Q;
    logic       CO;
    logic       BO;

    modport master (
        output LOAD, D, UP, DN,
        input  Q, CO, BO
    );

    modport slave (
        input  LOAD, D, UP, DN,
        output Q, CO, BO
    );
endinterface

// File: rtl/up_down_bcd_counter.sv
// Cascadable modulo-N up/down counter in the style of a 74LS192, retimed to one clock.
// CO/BO are combinational so a chain of stages all advance on the same edge.
module up_down_bcd_counter #(
    parameter int Delay   = 0,
    parameter int MODULUS = 10
) (
    input  logic                  CLK,
    input  logic                  CLR,
    up_down_bcd_counter_if.slave  bus
);
    localparam logic [3:0] LP_MAX = 4'(MODULUS - 1);
    localparam logic [4:0] LP_MOD = 5'(MODULUS);

    logic [3:0] r_cnt;
    logic [3:0] w_cnt_next;
    logic       w_up_only;
    logic       w_dn_only;
    logic       w_at_max;
    logic       w_at_zero;
    logic       w_count_ok;

    // Delay only matters to timing-annotated models; synthesized outputs carry no delay.
    if (Delay < 0 || MODULUS < 2 || MODULUS > 16) begin : g_param_out_of_range
    end

    assign w_up_only  = bus.UP & ~bus.DN;
    assign w_dn_only  = bus.DN & ~bus.UP;
    assign w_at_max   = (r_cnt == LP_MAX);
    assign w_at_zero  = (r_cnt == 4'd0);
    assign w_count_ok = ~bus.LOAD & ~CLR;

    // Out-of-range load values clamp to the top count so the state never leaves 0..MODULUS-1.
    always_comb begin
        w_cnt_next = r_cnt;
        if (bus.LOAD) begin
            w_cnt_next = ({1'b0, bus.D} < LP_MOD) ? bus.D : LP_MAX;
        end else if (w_up_only) begin
            w_cnt_next = w_at_max ? 4'd0 : r_cnt + 4'd1;
        end else if (w_dn_only) begin
            w_cnt_next = w_at_zero ? LP_MAX : r_cnt - 4'd1;
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_cnt <= 4'd0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    assign bus.Q  = r_cnt;
    assign bus.CO = w_up_only & w_count_ok & w_at_max;
    assign bus.BO = w_dn_only & w_count_ok & w_at_zero;
endmodule
